serdes_bitslip_ctrl: RTL

//  Sequences the BITSLIP input of one ISERDESE2 lane (NETWORKING, DDR, WIDTH-bit) to word-align it to a known training word.

---
 rtl/serdes_bitslip_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serdes_bitslip_ctrl.sv
// serdes_bitslip_ctrl
// Word-aligns one ISERDESE2 lane by pulsing BITSLIP until a stable run of
// training words is seen. The whole block lives in the CLKDIV domain.
// Flow: SETTLE lets the ISERDES pipeline flush, CHECK scores a window of
// valid words, and SLIP issues one pulse before settling again.
module serdes_bitslip_ctrl #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'h01,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 4,
  parameter int               CHECK_CYCLES  = 16,
  parameter int               MAX_SLIPS     = 16,
  localparam int              SLIP_W        = $clog2(MAX_SLIPS + 1)
) (
  input  logic              clk_rx_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              data_valid_i,
  output logic              bitslip_o,
  output logic              busy_o,
  output logic              locked_o,
  output logic              fail_o,
  output logic [SLIP_W-1:0] slip_cnt_o
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int WINDOW_W = $clog2(CHECK_CYCLES + 1);
  localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WINDOW_W-1:0] window_cnt_q, window_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic                bitslip_q, busy_q, locked_q, fail_q;
  logic                word_match;

  assign word_match = (data_i == TRAIN_PATTERN);

  // Next-state logic: sequences settle/check/slip and starts alignment from fresh counters
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    window_cnt_d = window_cnt_q;
    match_cnt_d  = match_cnt_q;
    slip_cnt_d   = slip_cnt_q;

    case (state_q)
      IDLE, LOCKED, FAIL: begin
        if (start_i) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          window_cnt_d = '0;
          match_cnt_d  = '0;
          slip_cnt_d   = '0;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES)) begin
          state_d      = CHECK;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      CHECK: begin
        if (data_valid_i) begin
          window_cnt_d = window_cnt_q + WINDOW_W'(1);
          match_cnt_d  = word_match ? (match_cnt_q + MATCH_W'(1)) : '0;
          if (word_match && (match_cnt_q == MATCH_W'(MATCH_COUNT - 1))) begin
            state_d = LOCKED;
          end else if (window_cnt_q == WINDOW_W'(CHECK_CYCLES - 1)) begin
            if (slip_cnt_q == SLIP_W'(MAX_SLIPS)) begin
              state_d = FAIL;
            end else begin
              state_d    = SLIP;
              slip_cnt_d = slip_cnt_q + SLIP_W'(1);
            end
          end
        end
      end

      SLIP: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
        window_cnt_d = '0;
        match_cnt_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs; reset drops any in-flight pulse
  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      window_cnt_q <= '0;
      match_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      window_cnt_q <= window_cnt_d;
      match_cnt_q  <= match_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= (state_d == SLIP);
      busy_q       <= (state_d == SETTLE) || (state_d == CHECK) || (state_d == SLIP);
      locked_q     <= (state_d == LOCKED);
      fail_q       <= (state_d == FAIL);
    end
  end

  assign bitslip_o  = bitslip_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign fail_o     = fail_q;
  assign slip_cnt_o = slip_cnt_q;

endmodule
